// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the accumulator ALU controller: FSM states, opcode
// classes, ALU operation codes and instruction field positions.
// No logic and no timing. Used by the decoder and the control FSM.
package alu_ctrl_pkg;

    // Instruction word layout: [15:13] op, [12:10] alu_op, [9:8] radr, [7:0] imm
    localparam int INSTR_W   = 16;
    localparam int OP_MSB    = 15;
    localparam int OP_LSB    = 13;
    localparam int ALU_MSB   = 12;
    localparam int ALU_LSB   = 10;
    localparam int RADR_MSB  = 9;
    localparam int RADR_LSB  = 8;
    localparam int IMM_MSB   = 7;
    localparam int IMM_LSB   = 0;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_DECODE  = 3'd2,
        ST_MEM     = 3'd3,
        ST_EXECUTE = 3'd4,
        ST_HALTED  = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        OP_NOP   = 3'b000,
        OP_ALU_R = 3'b001,
        OP_ALU_I = 3'b010,
        OP_ALU_M = 3'b011,
        OP_STR   = 3'b100,
        OP_JMP   = 3'b101,
        OP_JC    = 3'b110,
        OP_HALT  = 3'b111
    } op_t;

    // ALU operation codes passed straight through to the datapath.
    localparam logic [2:0] ALU_OP_ADD  = 3'b000;
    localparam logic [2:0] ALU_OP_SUB  = 3'b001;
    localparam logic [2:0] ALU_OP_AND  = 3'b010;
    localparam logic [2:0] ALU_OP_OR   = 3'b011;
    localparam logic [2:0] ALU_OP_XOR  = 3'b100;
    localparam logic [2:0] ALU_OP_NOT  = 3'b101;
    localparam logic [2:0] ALU_OP_SHL  = 3'b110;
    localparam logic [2:0] ALU_OP_PASS = 3'b111;

endpackage

// File: rtl/alu_instr_decoder.sv
// Splits a 16-bit instruction word into its fields and class flags.
// Purely combinational (zero latency); no flow control.
// Ports: instr in; op, alu_op, radr, imm, is_alu/is_alu_r/is_alu_i/is_alu_m/is_str out.
module alu_instr_decoder
    import alu_ctrl_pkg::*;
(
    input  logic [INSTR_W-1:0] instr,
    output op_t                op,
    output logic [2:0]         alu_op,
    output logic [1:0]         radr,
    output logic [7:0]         imm,
    output logic               is_alu,
    output logic               is_alu_r,
    output logic               is_alu_i,
    output logic               is_alu_m,
    output logic               is_str
);

    always_comb begin
        op       = op_t'(instr[OP_MSB:OP_LSB]);
        alu_op   = instr[ALU_MSB:ALU_LSB];
        radr     = instr[RADR_MSB:RADR_LSB];
        imm      = instr[IMM_MSB:IMM_LSB];
        is_alu_r = (op == OP_ALU_R);
        is_alu_i = (op == OP_ALU_I);
        is_alu_m = (op == OP_ALU_M);
        is_str   = (op == OP_STR);
        is_alu   = is_alu_r | is_alu_i | is_alu_m;
    end

endmodule

// File: rtl/alu_control_unit.sv
// Multi-cycle controller that fetches, decodes and sequences an accumulator ALU.
// Latency per instruction: 3 cycles ALU_R/I/STR, 4 ALU_M, 2 NOP/JMP/JC (plus fetch wait).
// Fetch stalls in FETCH with instr_req high until instr_valid; all outputs are registered.
// Ports: clk/reset; start/busy/halted control; instr_req/addr/valid/data fetch;
// dmem_re/addr data read; ALU drive (acumulator_ce, opcode, reg_file_*, data_*, direct_load) and c_out.
module alu_control_unit
    import alu_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        busy,
    output logic        halted,
    output logic        instr_req,
    output logic [7:0]  instr_addr,
    input  logic        instr_valid,
    input  logic [15:0] instr_data,
    output logic        dmem_re,
    output logic [7:0]  dmem_addr,
    output logic        acumulator_ce,
    output logic [2:0]  opcode,
    output logic [2:0]  reg_file_ce,
    output logic [1:0]  reg_file_adr,
    output logic        data_memory_read_enable,
    output logic [7:0]  data_direct,
    output logic        direct_load,
    input  logic        c_out
);

    state_t      state_q, state_d;
    logic [7:0]  pc_q, pc_d;
    logic        carry_q, carry_d;
    logic [15:0] instr_q, instr_d;

    logic        busy_q, busy_d;
    logic        halted_q, halted_d;
    logic        instr_req_q, instr_req_d;
    logic        dmem_re_q, dmem_re_d;
    logic [7:0]  dmem_addr_q, dmem_addr_d;
    logic        acc_ce_q, acc_ce_d;
    logic [2:0]  opcode_q, opcode_d;
    logic [2:0]  rf_ce_q, rf_ce_d;
    logic [1:0]  rf_adr_q, rf_adr_d;
    logic        dm_rd_en_q, dm_rd_en_d;
    logic [7:0]  data_direct_q, data_direct_d;
    logic        direct_load_q, direct_load_d;

    op_t         dec_op;
    logic [2:0]  dec_alu_op;
    logic [1:0]  dec_radr;
    logic [7:0]  dec_imm;
    logic        dec_is_alu, dec_is_alu_r, dec_is_alu_i, dec_is_alu_m, dec_is_str;

    // The latched instruction stays stable from DECODE through EXECUTE,
    // so decoding it directly is safe for both next-state and output logic.
    alu_instr_decoder u_dec (
        .instr    (instr_q),
        .op       (dec_op),
        .alu_op   (dec_alu_op),
        .radr     (dec_radr),
        .imm      (dec_imm),
        .is_alu   (dec_is_alu),
        .is_alu_r (dec_is_alu_r),
        .is_alu_i (dec_is_alu_i),
        .is_alu_m (dec_is_alu_m),
        .is_str   (dec_is_str)
    );

    // Next-state, PC and carry flag.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        carry_d = carry_q;
        instr_d = instr_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_FETCH;
                    pc_d    = 8'd0;
                end
            end
            ST_FETCH: begin
                if (instr_valid) begin
                    instr_d = instr_data;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                case (dec_op)
                    OP_ALU_M: state_d = ST_MEM;
                    OP_ALU_R, OP_ALU_I, OP_STR: state_d = ST_EXECUTE;
                    OP_NOP: begin
                        state_d = ST_FETCH;
                        pc_d    = pc_q + 8'd1;
                    end
                    OP_JMP: begin
                        state_d = ST_FETCH;
                        pc_d    = dec_imm;
                    end
                    OP_JC: begin
                        state_d = ST_FETCH;
                        pc_d    = carry_q ? dec_imm : pc_q + 8'd1;
                    end
                    default: state_d = ST_HALTED;
                endcase
            end
            ST_MEM: state_d = ST_EXECUTE;
            ST_EXECUTE: begin
                // Carry is only meaningful for ALU ops; STR leaves it alone.
                if (dec_is_alu) begin
                    carry_d = c_out;
                end
                pc_d    = pc_q + 8'd1;
                state_d = ST_FETCH;
            end
            ST_HALTED: begin
                if (start) begin
                    state_d = ST_FETCH;
                    pc_d    = 8'd0;
                    carry_d = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are computed from the upcoming state so that every output
    // is a flop and still lines up with the state it belongs to.
    always_comb begin
        busy_d        = (state_d != ST_IDLE) && (state_d != ST_HALTED);
        halted_d      = (state_d == ST_HALTED);
        instr_req_d   = (state_d == ST_FETCH);
        dmem_re_d     = 1'b0;
        dmem_addr_d   = 8'd0;
        acc_ce_d      = 1'b0;
        opcode_d      = 3'd0;
        rf_ce_d       = 3'b000;
        rf_adr_d      = 2'd0;
        dm_rd_en_d    = 1'b0;
        data_direct_d = 8'd0;
        direct_load_d = 1'b0;
        if (state_d == ST_MEM) begin
            dmem_re_d   = 1'b1;
            dmem_addr_d = dec_imm;
        end
        if (state_d == ST_EXECUTE) begin
            if (dec_is_alu) begin
                acc_ce_d = 1'b1;
                opcode_d = dec_alu_op;
            end
            if (dec_is_alu_r) begin
                rf_adr_d = dec_radr;
            end
            if (dec_is_alu_i) begin
                direct_load_d = 1'b1;
                data_direct_d = dec_imm;
            end
            if (dec_is_alu_m) begin
                dm_rd_en_d = 1'b1;
            end
            if (dec_is_str) begin
                rf_ce_d  = 3'b001;
                rf_adr_d = dec_radr;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            pc_q          <= 8'd0;
            carry_q       <= 1'b0;
            instr_q       <= 16'd0;
            busy_q        <= 1'b0;
            halted_q      <= 1'b0;
            instr_req_q   <= 1'b0;
            dmem_re_q     <= 1'b0;
            dmem_addr_q   <= 8'd0;
            acc_ce_q      <= 1'b0;
            opcode_q      <= 3'd0;
            rf_ce_q       <= 3'd0;
            rf_adr_q      <= 2'd0;
            dm_rd_en_q    <= 1'b0;
            data_direct_q <= 8'd0;
            direct_load_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            carry_q       <= carry_d;
            instr_q       <= instr_d;
            busy_q        <= busy_d;
            halted_q      <= halted_d;
            instr_req_q   <= instr_req_d;
            dmem_re_q     <= dmem_re_d;
            dmem_addr_q   <= dmem_addr_d;
            acc_ce_q      <= acc_ce_d;
            opcode_q      <= opcode_d;
            rf_ce_q       <= rf_ce_d;
            rf_adr_q      <= rf_adr_d;
            dm_rd_en_q    <= dm_rd_en_d;
            data_direct_q <= data_direct_d;
            direct_load_q <= direct_load_d;
        end
    end

    assign busy                    = busy_q;
    assign halted                  = halted_q;
    assign instr_req               = instr_req_q;
    assign instr_addr              = pc_q;
    assign dmem_re                 = dmem_re_q;
    assign dmem_addr               = dmem_addr_q;
    assign acumulator_ce           = acc_ce_q;
    assign opcode                  = opcode_q;
    assign reg_file_ce             = rf_ce_q;
    assign reg_file_adr            = rf_adr_q;
    assign data_memory_read_enable = dm_rd_en_q;
    assign data_direct             = data_direct_q;
    assign direct_load             = direct_load_q;

endmodule

// File: tb/tb_alu_control_unit.sv
// Directed bench for alu_control_unit: runs a short program through an
// instruction memory model, checking outputs cycle by cycle at negedge.
module tb_alu_control_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        busy;
    logic        halted;
    logic        instr_req;
    logic [7:0]  instr_addr;
    logic        instr_valid;
    logic [15:0] instr_data;
    logic        dmem_re;
    logic [7:0]  dmem_addr;
    logic        acumulator_ce;
    logic [2:0]  opcode;
    logic [2:0]  reg_file_ce;
    logic [1:0]  reg_file_adr;
    logic        data_memory_read_enable;
    logic [7:0]  data_direct;
    logic        direct_load;
    logic        c_out;

    logic [15:0] imem [256];
    logic        stall;
    int          n_cmp = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    alu_control_unit dut (
        .clk                     (clk),
        .reset                   (reset),
        .start                   (start),
        .busy                    (busy),
        .halted                  (halted),
        .instr_req               (instr_req),
        .instr_addr              (instr_addr),
        .instr_valid             (instr_valid),
        .instr_data              (instr_data),
        .dmem_re                 (dmem_re),
        .dmem_addr               (dmem_addr),
        .acumulator_ce           (acumulator_ce),
        .opcode                  (opcode),
        .reg_file_ce             (reg_file_ce),
        .reg_file_adr            (reg_file_adr),
        .data_memory_read_enable (data_memory_read_enable),
        .data_direct             (data_direct),
        .direct_load             (direct_load),
        .c_out                   (c_out)
    );

    task automatic check(input string tag, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Advance one cycle; the instruction memory answers a pending request
    // on the following edge unless stalled.
    task automatic step();
        @(negedge clk);
        instr_valid = instr_req && !stall;
        instr_data  = imem[instr_addr];
    endtask

    // All ALU drive outputs quiet.
    task automatic check_alu_idle(input string tag);
        check({tag, ".acc_ce"}, {15'd0, acumulator_ce}, 16'd0);
        check({tag, ".alu_bus"}, {4'd0, opcode, reg_file_ce, reg_file_adr, data_memory_read_enable,
                                  direct_load, 2'd0}, 16'd0);
        check({tag, ".data_direct"}, {8'd0, data_direct}, 16'd0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) imem[i] = 16'h0000;
        imem[8'h00] = 16'h4005;   // ALU_I add, imm 0x05
        imem[8'h01] = 16'h6C20;   // ALU_M alu_op 3, imm 0x20
        imem[8'h02] = 16'h8300;   // STR r3
        imem[8'h03] = 16'hC040;   // JC 0x40
        imem[8'h40] = 16'h2A00;   // ALU_R alu_op 2, r2
        imem[8'h41] = 16'hC050;   // JC 0x50
        imem[8'h42] = 16'hA0FF;   // JMP 0xFF
        imem[8'hFF] = 16'h0000;   // NOP
        reset = 1'b1; start = 1'b0; stall = 1'b0; c_out = 1'b1;
        instr_valid = 1'b0; instr_data = 16'h0000;

        step(); step();
        check("rst.busy", {15'd0, busy}, 16'd0);
        check("rst.halted", {15'd0, halted}, 16'd0);
        check("rst.instr_req", {15'd0, instr_req}, 16'd0);
        check("rst.instr_addr", {8'd0, instr_addr}, 16'd0);
        check_alu_idle("rst");

        // Reset wins over start in the same cycle.
        start = 1'b1;
        step();
        check("rst_prio.busy", {15'd0, busy}, 16'd0);
        check("rst_prio.instr_req", {15'd0, instr_req}, 16'd0);
        reset = 1'b0;

        step();                                   // FETCH @0
        start = 1'b0;
        check("f0.busy", {15'd0, busy}, 16'd1);
        check("f0.instr_req", {15'd0, instr_req}, 16'd1);
        check("f0.addr", {8'd0, instr_addr}, 16'h00);
        step();                                   // DECODE
        check("d0.instr_req", {15'd0, instr_req}, 16'd0);
        check_alu_idle("d0");
        step();                                   // EXECUTE ALU_I
        check("alui.acc_ce", {15'd0, acumulator_ce}, 16'd1);
        check("alui.direct_load", {15'd0, direct_load}, 16'd1);
        check("alui.data_direct", {8'd0, data_direct}, 16'h05);
        check("alui.opcode", {13'd0, opcode}, 16'd0);
        check("alui.rf_ce", {13'd0, reg_file_ce}, 16'd0);
        step();                                   // FETCH @1
        check("f1.addr", {8'd0, instr_addr}, 16'h01);
        check("f1.instr_req", {15'd0, instr_req}, 16'd1);
        check_alu_idle("f1");
        step();                                   // DECODE
        step();                                   // MEM
        check("mem.dmem_re", {15'd0, dmem_re}, 16'd1);
        check("mem.dmem_addr", {8'd0, dmem_addr}, 16'h20);
        check_alu_idle("mem");
        step();                                   // EXECUTE ALU_M
        check("alum.dmem_re", {15'd0, dmem_re}, 16'd0);
        check("alum.dm_rd_en", {15'd0, data_memory_read_enable}, 16'd1);
        check("alum.acc_ce", {15'd0, acumulator_ce}, 16'd1);
        check("alum.opcode", {13'd0, opcode}, 16'd3);
        check("alum.direct_load", {15'd0, direct_load}, 16'd0);
        step();                                   // FETCH @2
        check("f2.addr", {8'd0, instr_addr}, 16'h02);
        c_out = 1'b0;                             // STR must not latch this
        step();                                   // DECODE
        step();                                   // EXECUTE STR
        check("str.rf_ce", {13'd0, reg_file_ce}, 16'd1);
        check("str.rf_adr", {14'd0, reg_file_adr}, 16'd3);
        check("str.acc_ce", {15'd0, acumulator_ce}, 16'd0);
        step();                                   // FETCH @3
        check("f3.addr", {8'd0, instr_addr}, 16'h03);
        step();                                   // DECODE JC
        step();                                   // FETCH @0x40 (carry=1)
        check("jc_taken.addr", {8'd0, instr_addr}, 16'h40);
        check("jc_taken.instr_req", {15'd0, instr_req}, 16'd1);
        step();                                   // DECODE
        step();                                   // EXECUTE ALU_R, c_out=0
        check("alur.rf_adr", {14'd0, reg_file_adr}, 16'd2);
        check("alur.opcode", {13'd0, opcode}, 16'd2);
        check("alur.acc_ce", {15'd0, acumulator_ce}, 16'd1);
        check("alur.direct_load", {15'd0, direct_load}, 16'd0);
        check("alur.rf_ce", {13'd0, reg_file_ce}, 16'd0);
        step();                                   // FETCH @0x41
        step();                                   // DECODE JC
        step();                                   // FETCH @0x42 (carry=0)
        check("jc_not_taken.addr", {8'd0, instr_addr}, 16'h42);
        step();                                   // DECODE JMP
        step();                                   // FETCH @0xFF
        check("jmp.addr", {8'd0, instr_addr}, 16'hFF);
        step();                                   // DECODE NOP
        step();                                   // FETCH wraps to 0
        check("wrap.addr", {8'd0, instr_addr}, 16'h00);
        step();                                   // DECODE ALU_I
        step();                                   // EXECUTE
        check("pre_rst.acc_ce", {15'd0, acumulator_ce}, 16'd1);
        reset = 1'b1;
        step();                                   // reset taken in EXECUTE
        reset = 1'b0;
        check("rst_exec.busy", {15'd0, busy}, 16'd0);
        check("rst_exec.instr_req", {15'd0, instr_req}, 16'd0);
        check("rst_exec.addr", {8'd0, instr_addr}, 16'h00);
        check("rst_exec.dmem_re", {15'd0, dmem_re}, 16'd0);
        check_alu_idle("rst_exec");
        imem[8'h00] = 16'hE000;                   // HALT
        stall = 1'b1;
        step();                                   // still IDLE without start
        check("idle.busy", {15'd0, busy}, 16'd0);
        check("idle.instr_req", {15'd0, instr_req}, 16'd0);
        start = 1'b1;
        step();                                   // FETCH @0, stalled
        start = 1'b0;
        check("restart.addr", {8'd0, instr_addr}, 16'h00);
        check("restart.busy", {15'd0, busy}, 16'd1);
        for (int i = 0; i < 3; i++) begin
            step();
            check("wait.instr_req", {15'd0, instr_req}, 16'd1);
            check("wait.addr", {8'd0, instr_addr}, 16'h00);
            check("wait.dmem_re", {15'd0, dmem_re}, 16'd0);
            check_alu_idle("wait");
        end
        stall = 1'b0;
        instr_valid = 1'b1;
        step();                                   // DECODE HALT
        check("halt_dec.instr_req", {15'd0, instr_req}, 16'd0);
        step();                                   // HALTED
        check("halted.halted", {15'd0, halted}, 16'd1);
        check("halted.busy", {15'd0, busy}, 16'd0);
        step();
        check("halted_hold.halted", {15'd0, halted}, 16'd1);
        start = 1'b1;
        step();                                   // restart from HALTED
        start = 1'b0;
        check("unhalt.halted", {15'd0, halted}, 16'd0);
        check("unhalt.busy", {15'd0, busy}, 16'd1);
        check("unhalt.addr", {8'd0, instr_addr}, 16'h00);
        check("unhalt.instr_req", {15'd0, instr_req}, 16'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/alu_control_unit.md
ALU_CONTROL_UNIT -- requirements
Module: alu_control_unit

Interface
REQ-001 SHALL have one clock and synchronous active-high reset: clk input 1 rising-edge clock; reset input 1 synchronous active-high reset.
REQ-002 SHALL have these control ports: start input 1 begins program at PC 0; busy output 1 high outside IDLE/HALTED; halted output 1 high in HALTED.
REQ-003 SHALL have these instruction-fetch ports: instr_req output 1 fetch request; instr_addr output 8 program counter; instr_valid input 1 instr_data valid; instr_data input 16 instruction word.
REQ-004 SHALL have these data-memory ports: dmem_re output 1 data-memory read strobe; dmem_addr output 8 read address.
REQ-005 SHALL have these ALU-drive ports: acumulator_ce output 1; opcode output 3; reg_file_ce output 3; reg_file_adr output 2; data_memory_read_enable output 1; data_direct output 8; direct_load output 1; c_out input 1 ALU carry.

Function
REQ-006 SHALL decode the instruction as op=instr_data[15:13], alu_op=[12:10], radr=[9:8], imm=[7:0].
REQ-007 SHALL implement op 000 NOP, 001 ALU_R (register operand), 010 ALU_I (immediate operand), 011 ALU_M (memory operand at imm), 100 STR (accumulator to register radr), 101 JMP imm, 110 JC imm (jump if carry flag), 111 HALT.
REQ-008 SHALL use FSM states IDLE, FETCH, DECODE, MEM, EXECUTE, HALTED.
REQ-009 SHALL transition IDLE->FETCH on start, setting PC=0.
REQ-010 SHALL hold instr_req high in FETCH until instr_valid, latch instr_data on that edge, then go to DECODE; instr_valid outside FETCH is ignored.
REQ-011 SHALL go DECODE->MEM for ALU_M, DECODE->EXECUTE for ALU_R/ALU_I/STR, and DECODE->FETCH for NOP/JMP/JC (PC updated on that edge); HALT goes to HALTED.
REQ-012 SHALL assert dmem_re for exactly one cycle in MEM with dmem_addr=imm, then go to EXECUTE.
REQ-013 SHALL assert, in EXECUTE only, acumulator_ce=1 and opcode=alu_op for ALU_R/I/M; additionally reg_file_adr=radr for ALU_R, direct_load=1 with data_direct=imm for ALU_I, and data_memory_read_enable=1 for ALU_M.
REQ-014 SHALL drive reg_file_ce=3'b001 with reg_file_adr=radr and acumulator_ce=0 in EXECUTE for STR; otherwise reg_file_ce=3'b000.
REQ-015 SHALL latch c_out into the carry flag on the EXECUTE edge of ALU_R/I/M only; STR/NOP/jumps preserve it.
REQ-016 SHALL increment PC by 1 modulo 256 after EXECUTE or NOP (255 wraps to 0); JMP sets PC=imm; JC sets PC=imm if the carry flag is 1, else PC+1.
REQ-017 SHALL drive every ALU-drive output to 0 in all states other than EXECUTE.
REQ-018 SHALL remain in HALTED until start, which restarts at PC 0 with the carry flag cleared; start in any other non-IDLE state is ignored.
REQ-019 SHALL register all outputs (no combinational input-to-output path).
REQ-020 SHALL give a minimum instruction latency of FETCH(1+wait)+DECODE+EXECUTE=3 cycles for ALU_R/I/STR, 4 cycles for ALU_M, and 2 cycles for NOP/JMP/JC.

Reset
REQ-021 SHALL on reset go to IDLE, with PC=0, carry flag=0, latched instruction=0, and every output 0, including mid-fetch or mid-execute.
REQ-022 SHALL give reset priority over start and instr_valid in the same cycle.

Structure
REQ-023 SHALL place the state enum, the op-field encodings (3-bit), the alu_op encodings, and the field bit positions in shared package alu_ctrl_pkg.
REQ-024 SHALL factor decode into one combinational sub-module, alu_instr_decoder (instr -> op/alu_op/radr/imm plus class flags); the FSM, PC and carry flag stay in the top.

Verification
REQ-025 SHALL verify ALU_I: instr 0x4_05 (op 010, alu_op 000, imm 0x05) -> one EXECUTE cycle with acumulator_ce=1, direct_load=1, data_direct=0x05, opcode=000.
REQ-026 SHALL verify ALU_M: imm 0x20 -> dmem_re=1 with dmem_addr=0x20 for one cycle, next cycle data_memory_read_enable=1 and acumulator_ce=1.
REQ-027 SHALL verify JC: with c_out=1 in a prior ALU_I, JC 0x40 -> instr_addr=0x40; with c_out=0, instr_addr=PC+1.
REQ-028 SHALL verify wrap: JMP 0xFF, with NOP at 0xFF -> next instr_addr=0x00.
REQ-029 SHALL verify fetch wait: instr_valid held low 3 cycles -> instr_req stays high and PC stays constant, with no ALU outputs asserted.
REQ-030 SHALL verify reset in EXECUTE: all outputs 0 next cycle, state IDLE, busy=0; start -> instr_addr=0x00.
